sysbus_mem_responder: RTL and testbench

- Memory-side responder for the CPU system bus: the other end of the datapath's SysBus/DataIn interface.
- The CPU drives an address on SysBus and pulses Ale, then requests a read or a write.
- The block latches the address and inserts a programmable number of wait states.
- On a read it returns the word on DataOut, which feeds the CPU's DataIn. On a write it stores the word the CPU drives on SysBus.
- After each access the address auto-increments, so sequential (stack/block) accesses need no new Ale.

---
 rtl/sysbus_pkg.sv | 24 ++
 rtl/sysbus_mem_responder_if.sv | 31 +++
 rtl/sysbus_mem_array.sv | 39 +++
 rtl/sysbus_mem_responder.sv | 150 +++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_pkg
// Description : Shared types and constants for the system-bus memory responder.
// Revision    : 1.0
// ============================================================================
package sysbus_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } state_t;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/sysbus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_mem_responder_if
// Description : CPU system-bus signals between the datapath and the responder.
// Revision    : 1.0
// ============================================================================
interface sysbus_mem_responder_if;
  import sysbus_pkg::*;

  logic [BUS_W-1:0] SysBus;
  logic             Ale;
  logic             ReadReq;
  logic             WriteReq;
  logic [BUS_W-1:0] DataOut;
  logic             DataValid;
  logic             Ready;
  logic             AddrErr;
  logic             ProtoErr;

  modport master (
    output SysBus, Ale, ReadReq, WriteReq,
    input  DataOut, DataValid, Ready, AddrErr, ProtoErr
  );

  modport slave (
    input  SysBus, Ale, ReadReq, WriteReq,
    output DataOut, DataValid, Ready, AddrErr, ProtoErr
  );

endinterface
`default_nettype wire

// File: rtl/sysbus_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_mem_array
// Description : Single-port synchronous word RAM with registered read port.
// Revision    : 1.0
// ============================================================================
module sysbus_mem_array
  import sysbus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we,
  input  wire logic              re,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [BUS_W-1:0]  wdata,
  output logic      [BUS_W-1:0]  rdata
);

  logic [BUS_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sysbus_mem_responder
// Description : Memory-side SysBus responder with wait states and auto-increment.
// Revision    : 1.0
// ============================================================================
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input wire logic               Clock,
  input wire logic               nReset,
  sysbus_mem_responder_if.slave  bus
);

  localparam int CNT_W = 4;

  state_t           state, state_n;
  op_t              op, op_n;
  logic [BUS_W-1:0] addr, addr_n;
  logic [BUS_W-1:0] wdata, wdata_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid, valid_n;
  logic             ready, ready_n;
  logic             aerr, aerr_n;
  logic             perr, perr_n;
  logic             rd_zero, rd_zero_n;
  logic             mem_we, mem_re;
  logic             req_any, in_range;
  logic [BUS_W-1:0] mem_rdata;

  assign req_any  = bus.ReadReq | bus.WriteReq;
  assign in_range = ((addr >> ADDR_W) == '0);

  always_comb begin
    state_n   = state;
    op_n      = op;
    addr_n    = addr;
    wdata_n   = wdata;
    cnt_n     = cnt;
    ready_n   = ready;
    rd_zero_n = rd_zero;
    valid_n   = 1'b0;
    aerr_n    = 1'b0;
    perr_n    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        perr_n = req_any;
        if (bus.Ale) begin
          addr_n  = bus.SysBus;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (bus.Ale) begin
          addr_n = bus.SysBus;
          perr_n = req_any;
        end else if (bus.ReadReq && bus.WriteReq) begin
          perr_n = 1'b1;
        end else if (req_any) begin
          ready_n = 1'b0;
          op_n    = bus.WriteReq ? OpWrite : OpRead;
          if (bus.WriteReq) begin
            wdata_n = bus.SysBus;
          end
          if (WAIT_STATES == 0) begin
            state_n = ACCESS;
          end else begin
            cnt_n   = CNT_W'(WAIT_STATES - 1);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        perr_n = req_any | bus.Ale;
        if (cnt == '0) begin
          state_n = ACCESS;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACCESS: begin
        perr_n = req_any | bus.Ale;
        aerr_n = ~in_range;
        if (op == OpRead) begin
          valid_n   = 1'b1;
          mem_re    = in_range;
          rd_zero_n = ~in_range;
        end else begin
          mem_we = in_range;
        end
        addr_n  = addr + 1'b1;
        ready_n = 1'b1;
        state_n = ADDR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      op      <= OpRead;
      addr    <= '0;
      wdata   <= '0;
      cnt     <= '0;
      valid   <= 1'b0;
      ready   <= 1'b1;
      aerr    <= 1'b0;
      perr    <= 1'b0;
      rd_zero <= 1'b0;
    end else begin
      state   <= state_n;
      op      <= op_n;
      addr    <= addr_n;
      wdata   <= wdata_n;
      cnt     <= cnt_n;
      valid   <= valid_n;
      ready   <= ready_n;
      aerr    <= aerr_n;
      perr    <= perr_n;
      rd_zero <= rd_zero_n;
    end
  end

  sysbus_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (Clock),
    .rst_n (nReset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr[ADDR_W-1:0]),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  // An out-of-range read masks the RAM register so DataOut holds zero until the next read.
  assign bus.DataOut   = rd_zero ? '0 : mem_rdata;
  assign bus.DataValid = valid;
  assign bus.Ready     = ready;
  assign bus.AddrErr   = aerr;
  assign bus.ProtoErr  = perr;

endmodule
`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysbus_mem_responder
// Description : Self-checking bench: directed scenarios plus randomized model check.
// Revision    : 1.0
// ============================================================================
module tb_sysbus_mem_responder;

  localparam int WS = 1;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] sys_bus = '0;
  logic        ale = 1'b0;
  logic        rreq = 1'b0;
  logic        wreq = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  sysbus_mem_responder_if bus0 ();
  sysbus_mem_responder_if bus1 ();
  sysbus_mem_responder_if bus3 ();

  assign bus0.SysBus = sys_bus;  assign bus0.Ale = ale;
  assign bus0.ReadReq = rreq;    assign bus0.WriteReq = wreq;
  assign bus1.SysBus = sys_bus;  assign bus1.Ale = ale;
  assign bus1.ReadReq = rreq;    assign bus1.WriteReq = wreq;
  assign bus3.SysBus = sys_bus;  assign bus3.Ale = ale;
  assign bus3.ReadReq = rreq;    assign bus3.WriteReq = wreq;

  sysbus_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (.Clock(Clock), .nReset(nReset), .bus(bus0.slave));
  sysbus_mem_responder #(.ADDR_W(10), .WAIT_STATES(WS)) dut  (.Clock(Clock), .nReset(nReset), .bus(bus1.slave));
  sysbus_mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) dut3 (.Clock(Clock), .nReset(nReset), .bus(bus3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    #2 nReset = 1'b0;
    #4 nReset = 1'b1;
    step();
  endtask

  task automatic do_ale(input logic [15:0] a);
    ale = 1'b1;
    sys_bus = a;
    step();
    ale = 1'b0;
  endtask

  // One access on the WS=1 instance; returns what was seen when Ready came back.
  task automatic access(input bit is_wr, input logic [15:0] wd,
                        output logic [15:0] rd, output bit dv, output bit ae, output int lat);
    rreq = !is_wr;
    wreq = is_wr;
    sys_bus = wd;
    step();
    rreq = 1'b0;
    wreq = 1'b0;
    sys_bus = 16'($urandom);
    lat = 0;
    while (bus1.Ready !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    rd = bus1.DataOut;
    dv = bus1.DataValid;
    ae = bus1.AddrErr;
    chk("latency", lat, WS + 1);
    step();
    chk("dv_one_cycle", bus1.DataValid, 1'b0);
    chk("aerr_one_cycle", bus1.AddrErr, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, a, d, exp_rd, last_rd;
    bit          dv, ae, do_wr, oor, have_last;
    int          lat;
    int          first_dv [3];
    int          low_cnt  [3];
    logic [15:0] model_mem [int];
    int          wr_q [$];
    logic [15:0] burst_d [$];
    bit          burst_e [$];

    // Reset values
    #3 nReset = 1'b0;
    #4 nReset = 1'b1;
    step();
    chk("rst_ready", bus1.Ready, 1'b1);
    chk("rst_dataout", bus1.DataOut, 16'h0000);
    chk("rst_dv", bus1.DataValid, 1'b0);
    chk("rst_aerr", bus1.AddrErr, 1'b0);
    chk("rst_perr", bus1.ProtoErr, 1'b0);

    // Write/read sequence with auto-increment
    do_ale(16'h0010);
    access(1'b1, 16'hBEEF, rd, dv, ae, lat);
    chk("wr_no_dv", dv, 1'b0);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("rd11_dv", dv, 1'b1);
    access(1'b1, 16'h5A5A, rd, dv, ae, lat);
    do_ale(16'h0012);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("autoinc_0012", rd, 16'h5A5A);
    do_ale(16'h0010);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("readback_beef", rd, 16'hBEEF);
    chk("readback_dv", dv, 1'b1);
    chk("readback_aerr", ae, 1'b0);

    // Latency across WAIT_STATES = 0, 1, 3
    do_reset();
    do_ale(16'h0020);
    rreq = 1'b1;
    step();
    rreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      first_dv[i] = -1;
      low_cnt[i] = 0;
    end
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      if (bus0.Ready === 1'b0) low_cnt[0]++;
      if (bus1.Ready === 1'b0) low_cnt[1]++;
      if (bus3.Ready === 1'b0) low_cnt[2]++;
      if (bus0.DataValid === 1'b1 && first_dv[0] < 0) first_dv[0] = c;
      if (bus1.DataValid === 1'b1 && first_dv[1] < 0) first_dv[1] = c;
      if (bus3.DataValid === 1'b1 && first_dv[2] < 0) first_dv[2] = c;
    end
    chk("ws0_dv_edge", first_dv[0], 1);
    chk("ws1_dv_edge", first_dv[1], 2);
    chk("ws3_dv_edge", first_dv[2], 4);
    chk("ws0_ready_low", low_cnt[0], 1);
    chk("ws1_ready_low", low_cnt[1], 2);
    chk("ws3_ready_low", low_cnt[2], 4);

    // Out-of-range read and write
    do_ale(16'h0000);
    access(1'b1, 16'h1111, rd, dv, ae, lat);
    do_ale(16'h0400);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("oor_rd_data", rd, 16'h0000);
    chk("oor_rd_dv", dv, 1'b1);
    chk("oor_rd_aerr", ae, 1'b1);
    do_ale(16'h0400);
    access(1'b1, 16'hDEAD, rd, dv, ae, lat);
    chk("oor_wr_aerr", ae, 1'b1);
    chk("oor_wr_dataout", rd, 16'h0000);
    do_ale(16'h0000);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("oor_wr_discarded", rd, 16'h1111);

    // Boundary burst with ReadReq held high
    do_ale(16'h03FF);
    access(1'b1, 16'h7777, rd, dv, ae, lat);
    do_ale(16'h03FF);
    rreq = 1'b1;
    for (int c = 0; c < 3 * (WS + 2); c++) begin
      step();
      if (bus1.DataValid === 1'b1) begin
        burst_d.push_back(bus1.DataOut);
        burst_e.push_back(bus1.AddrErr);
      end
    end
    rreq = 1'b0;
    step();
    chk("burst_count", burst_d.size(), 3);
    if (burst_d.size() == 3) begin
      chk("burst_3ff_data", burst_d[0], 16'h7777);
      chk("burst_3ff_aerr", burst_e[0], 1'b0);
      chk("burst_400_data", burst_d[1], 16'h0000);
      chk("burst_400_aerr", burst_e[1], 1'b1);
      chk("burst_401_aerr", burst_e[2], 1'b1);
    end

    // Address wrap 0xFFFF -> 0x0000
    do_ale(16'hFFFF);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("ffff_aerr", ae, 1'b1);
    access(1'b1, 16'h1234, rd, dv, ae, lat);
    chk("wrap_wr_aerr", ae, 1'b0);
    do_ale(16'h0000);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("wrap_data", rd, 16'h1234);

    // Protocol errors
    do_reset();
    rreq = 1'b1;
    step();
    rreq = 1'b0;
    chk("pe_idle", bus1.ProtoErr, 1'b1);
    chk("pe_idle_dv", bus1.DataValid, 1'b0);
    chk("pe_idle_ready", bus1.Ready, 1'b1);
    step();
    chk("pe_idle_pulse", bus1.ProtoErr, 1'b0);
    do_ale(16'h0030);
    access(1'b1, 16'hAAAA, rd, dv, ae, lat);
    do_ale(16'h0030);
    rreq = 1'b1;
    wreq = 1'b1;
    sys_bus = 16'h4444;
    step();
    rreq = 1'b0;
    wreq = 1'b0;
    chk("pe_both", bus1.ProtoErr, 1'b1);
    chk("pe_both_ready", bus1.Ready, 1'b1);
    chk("pe_both_dv", bus1.DataValid, 1'b0);
    step();
    chk("pe_both_pulse", bus1.ProtoErr, 1'b0);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("pe_both_nochange", rd, 16'hAAAA);
    do_ale(16'h0030);
    rreq = 1'b1;
    step();
    rreq = 1'b0;
    wreq = 1'b1;
    sys_bus = 16'h5555;
    step();
    wreq = 1'b0;
    chk("pe_wait", bus1.ProtoErr, 1'b1);
    step();
    chk("pe_wait_rd_dv", bus1.DataValid, 1'b1);
    chk("pe_wait_rd_data", bus1.DataOut, 16'hAAAA);
    step();
    do_ale(16'h0030);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("pe_wait_nochange", rd, 16'hAAAA);

    // Asynchronous reset during the WAIT of a write
    do_ale(16'h0030);
    wreq = 1'b1;
    sys_bus = 16'h9999;
    step();
    wreq = 1'b0;
    chk("arst_ready_before", bus1.Ready, 1'b0);
    #3 nReset = 1'b0;
    #1;
    chk("arst_ready", bus1.Ready, 1'b1);
    chk("arst_dataout", bus1.DataOut, 16'h0000);
    chk("arst_dv", bus1.DataValid, 1'b0);
    chk("arst_aerr", bus1.AddrErr, 1'b0);
    chk("arst_perr", bus1.ProtoErr, 1'b0);
    #2 nReset = 1'b1;
    step();
    do_ale(16'h0030);
    access(1'b0, 16'h0000, rd, dv, ae, lat);
    chk("arst_aborted_write", rd, 16'hAAAA);

    // Randomized accesses against a word-array model
    have_last = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 40; i++) begin
      do_wr = (wr_q.size() == 0) || ($urandom_range(0, 1) == 1);
      oor = ($urandom_range(0, 4) == 0);
      if (oor) a = 16'(32'h0400 + $urandom_range(0, 32'hFBFF));
      else if (do_wr) a = 16'($urandom_range(0, 1023));
      else a = 16'(wr_q[$urandom_range(0, wr_q.size() - 1)]);
      d = 16'($urandom);
      do_ale(a);
      access(do_wr, d, rd, dv, ae, lat);
      chk("rnd_aerr", ae, oor);
      chk("rnd_dv", dv, !do_wr);
      if (!do_wr) begin
        exp_rd = oor ? 16'h0000 : model_mem[int'(a)];
        chk("rnd_rdata", rd, exp_rd);
        last_rd = exp_rd;
        have_last = 1'b1;
      end else begin
        if (!oor) begin
          model_mem[int'(a)] = d;
          wr_q.push_back(int'(a));
        end
        if (have_last) chk("rnd_dataout_hold", rd, last_rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
